// File: rtl/ama_riscv_ex_mem_stage_pkg.sv
// Shared constants and helpers for the EX->MEM stage: writeback source
// selects, load/store width codes and the misalignment rule.
package ama_riscv_ex_mem_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // funct3[1:0] encodes the access width for both signed and unsigned forms
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ama_riscv_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the memory
// word and sign- or zero-extends it according to funct3.
module ama_riscv_load_align
    import ama_riscv_ex_mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            FUNCT3_B:  data = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_BU: data = {24'd0, byte_sel};
            FUNCT3_H:  data = {{16{half_sel[15]}}, half_sel};
            FUNCT3_HU: data = {16'd0, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/ama_riscv_ex_mem_stage.sv
// EX->MEM pipeline register: issues the data-memory request on fire, then
// aligns load data and muxes writeback/forwarding values in the MEM cycle.
module ama_riscv_ex_mem_stage
    import ama_riscv_ex_mem_stage_pkg::*;
#(
    parameter int DMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               flush,
    input  logic [31:0]        alu_out,
    input  logic [31:0]        rs2_data,
    input  logic [31:0]        pc_plus4,
    input  logic [4:0]         rd_addr,
    input  logic               reg_we,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic [2:0]         funct3,
    input  logic [1:0]         wb_sel,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               mem_ready,
    output logic               mem_valid,
    output logic [4:0]         mem_rd_addr,
    output logic               mem_reg_we,
    output logic               mem_is_load,
    output logic [31:0]        mem_fwd_data,
    output logic [31:0]        mem_wb_data,
    output logic               mem_misaligned
);

    logic        valid_q, valid_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] pc4_q, pc4_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_we_q, reg_we_d;
    logic        mem_rd_q, mem_rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        mis_q, mis_d;

    logic        fire;
    logic        ex_mis;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] load_data;

    assign off      = alu_out[1:0];
    assign ex_ready = ~valid_q | mem_ready;
    assign fire     = ex_valid & ex_ready & ~flush;
    // Only memory ops can be misaligned; ALU ops reuse funct3 for other meanings
    assign ex_mis   = (mem_rd | mem_wr) & is_misaligned(funct3, off);

    always_comb begin
        be         = 4'b1111;
        dmem_wdata = rs2_data;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << off;
                dmem_wdata = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << off;
                dmem_wdata = {2{rs2_data[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                dmem_wdata = rs2_data;
            end
        endcase
    end

    assign dmem_en   = fire & (mem_rd | mem_wr) & ~ex_mis;
    assign dmem_we   = (dmem_en & mem_wr) ? be : 4'b0000;
    assign dmem_addr = alu_out[DMEM_AW+1:2];

    always_comb begin
        valid_d  = valid_q;
        alu_d    = alu_q;
        pc4_d    = pc4_q;
        rd_d     = rd_q;
        reg_we_d = reg_we_q;
        mem_rd_d = mem_rd_q;
        funct3_d = funct3_q;
        wb_sel_d = wb_sel_q;
        mis_d    = mis_q;
        if (fire) begin
            valid_d  = 1'b1;
            alu_d    = alu_out;
            pc4_d    = pc_plus4;
            rd_d     = rd_addr;
            reg_we_d = reg_we;
            mem_rd_d = mem_rd;
            funct3_d = funct3;
            wb_sel_d = wb_sel;
            mis_d    = ex_mis;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            alu_q    <= '0;
            pc4_q    <= '0;
            rd_q     <= '0;
            reg_we_q <= 1'b0;
            mem_rd_q <= 1'b0;
            funct3_q <= '0;
            wb_sel_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            alu_q    <= alu_d;
            pc4_q    <= pc4_d;
            rd_q     <= rd_d;
            reg_we_q <= reg_we_d;
            mem_rd_q <= mem_rd_d;
            funct3_q <= funct3_d;
            wb_sel_q <= wb_sel_d;
            mis_q    <= mis_d;
        end
    end

    ama_riscv_load_align u_load_align (
        .rdata  (dmem_rdata),
        .off    (alu_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_comb begin
        mem_wb_data  = 32'd0;
        mem_fwd_data = 32'd0;
        case (wb_sel_q)
            WB_SEL_ALU: begin
                mem_wb_data  = alu_q;
                mem_fwd_data = alu_q;
            end
            WB_SEL_MEM: mem_wb_data = load_data;
            WB_SEL_PC4: begin
                mem_wb_data  = pc4_q;
                mem_fwd_data = pc4_q;
            end
            default: begin
                mem_wb_data  = 32'd0;
                mem_fwd_data = 32'd0;
            end
        endcase
    end

    assign mem_valid      = valid_q;
    assign mem_rd_addr    = rd_q;
    assign mem_reg_we     = valid_q & reg_we_q & ~mis_q;
    assign mem_is_load    = valid_q & mem_rd_q;
    assign mem_misaligned = mis_q;

endmodule

// File: tb/tb_ama_riscv_ex_mem_stage.sv
// Directed bench for the EX->MEM stage: a vector table for single
// instructions plus hand sequences for reset, stall/flush and back-to-back.
module tb_ama_riscv_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        flush;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [1:0]  wb_sel;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        mem_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_we;
    logic        mem_is_load;
    logic [31:0] mem_fwd_data;
    logic [31:0] mem_wb_data;
    logic        mem_misaligned;

    int checks = 0;
    int errors = 0;

    ama_riscv_ex_mem_stage #(.DMEM_AW(14)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .flush          (flush),
        .alu_out        (alu_out),
        .rs2_data       (rs2_data),
        .pc_plus4       (pc_plus4),
        .rd_addr        (rd_addr),
        .reg_we         (reg_we),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .funct3         (funct3),
        .wb_sel         (wb_sel),
        .dmem_en        (dmem_en),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .mem_ready      (mem_ready),
        .mem_valid      (mem_valid),
        .mem_rd_addr    (mem_rd_addr),
        .mem_reg_we     (mem_reg_we),
        .mem_is_load    (mem_is_load),
        .mem_fwd_data   (mem_fwd_data),
        .mem_wb_data    (mem_wb_data),
        .mem_misaligned (mem_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rwe;
        logic        mrd;
        logic        mwr;
        logic [2:0]  f3;
        logic [1:0]  wbs;
        logic [31:0] rdata;
        logic        e_en;
        logic [3:0]  e_we;
        logic [13:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic [31:0] e_fwd;
        logic        e_rwe;
        logic        e_mis;
        logic        e_ld;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; flush = 1'b0;
        alu_out = '0; rs2_data = '0; pc_plus4 = '0; rd_addr = '0;
        reg_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = '0; wb_sel = '0;
    endtask

    task automatic drive_ex(input logic [31:0] a, input logic [31:0] r2, input logic [31:0] p4,
                            input logic [4:0] rd, input logic rwe, input logic mrd, input logic mwr,
                            input logic [2:0] f3, input logic [1:0] wbs);
        ex_valid = 1'b1;
        alu_out = a; rs2_data = r2; pc_plus4 = p4; rd_addr = rd;
        reg_we = rwe; mem_rd = mrd; mem_wr = mwr; funct3 = f3; wb_sel = wbs;
    endtask

    initial begin
        //          alu           rs2           pc4        rd    rwe   mrd   mwr   f3      wbs   rdata          en    we       addr       wdata         wb            fwd        rwe   mis   ld
        vecs[0]  = '{32'h1003, 32'hAABBCCDD, 32'h0,   5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 2'd0, 32'h0,        1'b1, 4'b1000, 14'h400, 32'hDDDDDDDD, 32'h1003,     32'h1003, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h2003, 32'h0,        32'h0,   5'd5, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 32'h80FF7F01, 1'b1, 4'b0000, 14'h800, 32'h0,        32'hFFFFFF80, 32'h0,    1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h2002, 32'h0,        32'h0,   5'd6, 1'b1, 1'b1, 1'b0, 3'b101, 2'd1, 32'h80FF7F01, 1'b1, 4'b0000, 14'h800, 32'h0,        32'h000080FF, 32'h0,    1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h2001, 32'h0,        32'h0,   5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 2'd1, 32'h80FF7F01, 1'b1, 4'b0000, 14'h800, 32'h0,        32'h0000007F, 32'h0,    1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h2002, 32'h12345678, 32'h0,   5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 2'd0, 32'h0,        1'b0, 4'b0000, 14'h800, 32'h12345678, 32'h2002,     32'h2002, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h1001, 32'h0,        32'h0,   5'd8, 1'b1, 1'b1, 1'b0, 3'b001, 2'd1, 32'h80FF7F01, 1'b0, 4'b0000, 14'h400, 32'h0,        32'h00007F01, 32'h0,    1'b0, 1'b1, 1'b1};
        vecs[6]  = '{32'h1002, 32'h0000BEEF, 32'h0,   5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 2'd0, 32'h0,        1'b1, 4'b1100, 14'h400, 32'hBEEFBEEF, 32'h1002,     32'h1002, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h5,    32'h0,        32'h0,   5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 32'h0,        1'b0, 4'b0000, 14'h001, 32'h0,        32'h5,        32'h5,    1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h200,  32'h0,        32'h104, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd2, 32'h0,        1'b0, 4'b0000, 14'h080, 32'h0,        32'h104,      32'h104,  1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h3000, 32'h0,        32'h0,   5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 2'd1, 32'hCAFEF00D, 1'b1, 4'b0000, 14'hC00, 32'h0,        32'hCAFEF00D, 32'h0,    1'b1, 1'b0, 1'b1};
        vecs[10] = '{32'h7,    32'h0,        32'h0,   5'd2, 1'b1, 1'b0, 1'b0, 3'b000, 2'd3, 32'h0,        1'b0, 4'b0000, 14'h001, 32'h0,        32'h0,        32'h0,    1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h2003, 32'h0,        32'h0,   5'd4, 1'b1, 1'b1, 1'b0, 3'b100, 2'd1, 32'h80FF7F01, 1'b1, 4'b0000, 14'h800, 32'h0,        32'h00000080, 32'h0,    1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        mem_ready = 1'b1;
        dmem_rdata = '0;
        drive_idle();

        // Reset held for two cycles, then bubbles
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
            chk("rst_mem_reg_we", {31'd0, mem_reg_we}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_misaligned", {31'd0, mem_misaligned}, 32'd0);
        chk("rst_is_load", {31'd0, mem_is_load}, 32'd0);
        chk("rst_wb_data", mem_wb_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bubble_mem_valid", {31'd0, mem_valid}, 32'd0);
            chk("bubble_mem_reg_we", {31'd0, mem_reg_we}, 32'd0);
            chk("bubble_dmem_en", {31'd0, dmem_en}, 32'd0);
            chk("bubble_ex_ready", {31'd0, ex_ready}, 32'd1);
        end

        // Table of single instructions: request side, then MEM side one cycle later
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_ex(vecs[i].alu, vecs[i].rs2, vecs[i].pc4, vecs[i].rd, vecs[i].rwe,
                     vecs[i].mrd, vecs[i].mwr, vecs[i].f3, vecs[i].wbs);
            #1;
            chk($sformatf("v%0d_dmem_en", i), {31'd0, dmem_en}, {31'd0, vecs[i].e_en});
            chk($sformatf("v%0d_dmem_we", i), {28'd0, dmem_we}, {28'd0, vecs[i].e_we});
            chk($sformatf("v%0d_dmem_addr", i), {18'd0, dmem_addr}, {18'd0, vecs[i].e_addr});
            if (vecs[i].mwr)
                chk($sformatf("v%0d_dmem_wdata", i), dmem_wdata, vecs[i].e_wdata);
            @(posedge clk);
            #1;
            drive_idle();
            dmem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_mem_valid", i), {31'd0, mem_valid}, 32'd1);
            chk($sformatf("v%0d_rd_addr", i), {27'd0, mem_rd_addr}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_wb_data", i), mem_wb_data, vecs[i].e_wb);
            chk($sformatf("v%0d_fwd_data", i), mem_fwd_data, vecs[i].e_fwd);
            chk($sformatf("v%0d_reg_we", i), {31'd0, mem_reg_we}, {31'd0, vecs[i].e_rwe});
            chk($sformatf("v%0d_misaligned", i), {31'd0, mem_misaligned}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d_is_load", i), {31'd0, mem_is_load}, {31'd0, vecs[i].e_ld});
            $display("vec %0d alu=0x%08h f3=%0d wb=0x%08h fwd=0x%08h", i, vecs[i].alu, vecs[i].f3, mem_wb_data, mem_fwd_data);
        end

        // Stall: MEM holds an ADD while downstream is not ready
        @(negedge clk);
        drive_idle();
        drive_ex(32'h55, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        drive_ex(32'h100, 32'h11223344, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 2'd0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) flush = 1'b1;
            #1;
            chk("stall_ex_ready", {31'd0, ex_ready}, 32'd0);
            chk("stall_dmem_en", {31'd0, dmem_en}, 32'd0);
            chk("stall_dmem_we", {28'd0, dmem_we}, 32'd0);
            @(negedge clk);
            chk("stall_mem_valid", {31'd0, mem_valid}, 32'd1);
            chk("stall_fwd_data", mem_fwd_data, 32'h55);
            chk("stall_rd_addr", {27'd0, mem_rd_addr}, 32'd10);
            $display("stall cycle %0d ex_ready=%0b fwd=0x%08h", i, ex_ready, mem_fwd_data);
        end

        // Flush with fire conditions otherwise met
        mem_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("flush_dmem_en", {31'd0, dmem_en}, 32'd0);
        @(negedge clk);
        chk("flush_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("flush_mem_reg_we", {31'd0, mem_reg_we}, 32'd0);
        $display("flush mem_valid=%0b", mem_valid);
        drive_idle();

        // Back-to-back ADD then JAL with no bubble
        @(negedge clk);
        drive_ex(32'h5, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
        @(negedge clk);
        chk("b2b_add_valid", {31'd0, mem_valid}, 32'd1);
        chk("b2b_add_fwd", mem_fwd_data, 32'h5);
        $display("b2b add fwd=0x%08h", mem_fwd_data);
        drive_ex(32'h400, 32'h0, 32'h104, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd2);
        @(negedge clk);
        chk("b2b_jal_valid", {31'd0, mem_valid}, 32'd1);
        chk("b2b_jal_fwd", mem_fwd_data, 32'h104);
        chk("b2b_jal_wb", mem_wb_data, 32'h104);
        $display("b2b jal fwd=0x%08h", mem_fwd_data);
        drive_idle();
        @(negedge clk);
        chk("b2b_drain_valid", {31'd0, mem_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ama_riscv_ex_mem_stage.md
Name: ama_riscv_ex_mem_stage

Overview:
EX->MEM pipeline stage directly downstream of the ALU. It registers the ALU result and its control, and issues the data-memory request (address, byte enables, replicated store data) in the same cycle the ALU result is accepted. In the MEM cycle it aligns load data and produces writeback and forwarding data. It also detects misaligned accesses and suppresses them.

Parameters:
DMEM_AW, 14, word-address width driven to data memory; dmem_addr = alu_out[DMEM_AW+1:2]

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  EX holds a valid instruction
ex_ready  out  1  stage can accept the EX instruction
flush  in  1  kill the EX instruction (branch/jump redirect)
alu_out  in  32  ALU out_s; effective address for load/store
rs2_data  in  32  store data
pc_plus4  in  32  link value for JAL/JALR
rd_addr  in  5  destination register
reg_we  in  1  instruction writes rd
mem_rd  in  1  load
mem_wr  in  1  store
funct3  in  3  access width/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
wb_sel  in  2  writeback source: ALU / MEM / PC+4
dmem_en  out  1  memory request this cycle
dmem_we  out  4  byte write enables
dmem_addr  out  DMEM_AW  word address
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid the cycle after request, held while dmem_en=0
mem_ready  in  1  downstream (WB) accepts the MEM instruction
mem_valid  out  1  MEM register holds a valid instruction
mem_rd_addr  out  5  registered rd
mem_reg_we  out  1  registered write enable, gated by mem_valid and ~mem_misaligned
mem_is_load  out  1  load in MEM; used by hazard unit for load-use stall
mem_fwd_data  out  32  ALU or PC+4 result for forwarding (never load data)
mem_wb_data  out  32  final writeback data
mem_misaligned  out  1  registered misalignment flag

Behaviour:
- Reset: all registered state, including mem_valid, mem_reg_we, mem_misaligned, mem_is_load, data registers and mem_wb_sel, goes to 0. Combinational outputs follow from this state.
- ex_ready = ~mem_valid | mem_ready (pipeline register, no skid buffer).
- fire = ex_valid & ex_ready & ~flush.
- On fire, the MEM register loads all EX fields and sets mem_valid=1.
- If ex_ready=1 and there is no fire, mem_valid<=0 (bubble).
- If ex_ready=0 (stall), the MEM register holds.
- flush affects only the EX instruction; the MEM contents are never killed.
- flush together with a stall: hold, and no memory access.
- Misalignment, with off = alu_out[1:0]:
  - H access with off[0]=1 is misaligned.
  - W access with off!=0 is misaligned.
  - B access is never misaligned.
- dmem_en = fire & (mem_rd|mem_wr) & ~misaligned. dmem_we is 0 unless dmem_en & mem_wr.
- Store byte enables: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111.
- Store data: SB {4{rs2[7:0]}}; SH {2{rs2[15:0]}}; SW rs2.
- A misaligned instruction still advances with mem_misaligned=1 and mem_reg_we=0. Trap handling is out of scope.
- Load align (MEM cycle), using registered off and funct3:
  - LB/LBU select byte off, then sign- or zero-extend.
  - LH/LHU select halfword off[1], then extend.
  - LW uses the full word.
- mem_wb_data by wb_sel: ALU -> registered alu_out; MEM -> aligned load; PC+4 -> registered pc_plus4; reserved encoding -> 0.
- mem_fwd_data is the same mux without the MEM leg; it outputs 0 for MEM.
- mem_is_load = mem_valid & registered mem_rd.
- Latency: one cycle from EX fire to MEM outputs. Throughput is one instruction per cycle when there is no stall.
- While stalled, dmem_rdata is held by memory because dmem_en=0, so a load result remains stable.

Decomposition:
- ama_riscv_defines.v gains the shared constants:
  - WB_SEL_ALU=2'd0, WB_SEL_MEM=2'd1, WB_SEL_PC4=2'd2.
  - funct3 width codes: FUNCT3_B=3'b000, H=3'b001, W=3'b010, BU=3'b100, HU=3'b101.
- One sub-module, ama_riscv_load_align: combinational, with inputs rdata[31:0], off[1:0] and funct3, and output data[31:0].

Test Plan:
- Reset and bubbles: rst_n=0 for 2 cycles, then ex_valid=0 -> mem_valid=0, mem_reg_we=0, dmem_en=0 throughout.
- SB: alu_out=0x1003, rs2=0xAABBCCDD, SB -> dmem_en=1, dmem_we=4'b1000, dmem_wdata=0xDDDDDDDD, dmem_addr=0x400.
- LB sign and LHU: dmem_rdata=0x80FF7F01.
  - LB off=3 -> mem_wb_data=0xFFFFFF80.
  - LHU off=2 -> 0x000080FF.
  - LB off=1 -> 0x0000007F.
- Misaligned: SW at alu_out=0x2002 -> dmem_en=0, dmem_we=0; next cycle mem_misaligned=1, mem_reg_we=0. LH at 0x1001 behaves the same.
- Stall and flush:
  - mem_ready=0 with mem_valid=1 -> ex_ready=0; MEM outputs hold for 3 cycles; no dmem_en even with ex_valid=1.
  - flush=1 with fire conditions met -> dmem_en=0, next mem_valid=0.
- Back-to-back: ADD (alu_out=5, wb_sel=ALU), then JAL (pc_plus4=0x104) -> consecutive cycles give mem_fwd_data=5 then 0x104, mem_valid stays 1.
